vip_frame_reader_ctrl: RTL and testbench



---
 rtl/vip_frame_reader_pkg.sv | 28 ++
 rtl/vip_pixel_fifo.sv | 85 ++++++++
 rtl/vip_frame_reader_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_vip_frame_reader_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vip_frame_reader_pkg.sv
// ============================================================================
// Module   : vip_frame_reader_pkg
// Purpose  : Shared types and constants for the VIP frame reader.
//            Contents: the output FSM state type, the VIP packet type code
//            carried in the header beat, and the SDRAM word size in bytes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package vip_frame_reader_pkg;

    // Output sequencer states: wait for enable, header beat, pixels, gap cycle
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Packet type nibble for an active video packet
    localparam logic [3:0] VIP_PKT_VIDEO = 4'h0;

    // Avalon-MM addresses are byte addresses; each pixel is one 32-bit word
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

`default_nettype wire

// File: rtl/vip_pixel_fifo.sv
// ============================================================================
// Module   : vip_pixel_fifo
// Purpose  : Synchronous show-ahead FIFO. The head entry is visible on
//            rd_data whenever empty is low; pop consumes it.
// Ports    : clk, reset_n   - clock, asynchronous active-low reset
//            push/push_data - write port (a push while full is dropped)
//            pop/rd_data    - read port, rd_data is the current head
//            count/empty/full - occupancy status
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vip_pixel_fifo
    import vip_frame_reader_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == CW'(0));
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Push and pop together leave the occupancy unchanged
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vip_frame_reader_ctrl.sv
// ============================================================================
// Module   : vip_frame_reader_ctrl
// Purpose  : Fetches one frame of 32-bit pixels from SDRAM with fixed-size
//            Avalon-MM read bursts, buffers them in a pixel FIFO and emits
//            each frame as a VIP Avalon-ST video packet (header + pixels).
// Ports    : clk, reset_n          - clock, asynchronous active-low reset
//            enable, base_addr     - run control, frame byte address
//            avm_*                 - Avalon-MM burst read master
//            dout_*                - Avalon-ST video source
//            busy, frame_done      - frame in progress, last-pixel pulse
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vip_frame_reader_ctrl
    import vip_frame_reader_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int BURST      = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [31:0] base_addr,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic [4:0]  avm_burstcount,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic [31:0] dout_data,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic        busy,
    output logic        frame_done
);

    localparam int TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int CW    = $clog2(TOTAL+1);
    localparam int FCW   = $clog2(FIFO_DEPTH+1);

    state_e      state_q, state_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic [CW-1:0] req_cnt_q, req_cnt_d;
    logic [CW-1:0] emit_cnt_q, emit_cnt_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic        avm_read_q, avm_read_d;
    logic [31:0] avm_address_q, avm_address_d;
    logic [4:0]  avm_burstcount_q, avm_burstcount_d;

    logic        accept;
    logic [31:0] remaining;
    logic [31:0] burst_len;
    logic [31:0] free_words;

    logic           fifo_pop;
    logic [31:0]    fifo_head;
    logic [FCW-1:0] fifo_count;
    logic           fifo_empty;
    logic           fifo_full;

    vip_pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (avm_readdatavalid),
        .push_data (avm_readdata),
        .pop       (fifo_pop),
        .rd_data   (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_comb begin
        state_d          = state_q;
        rd_addr_d        = rd_addr_q;
        req_cnt_d        = req_cnt_q;
        emit_cnt_d       = emit_cnt_q;
        avm_read_d       = avm_read_q;
        avm_address_d    = avm_address_q;
        avm_burstcount_d = avm_burstcount_q;
        dout_valid       = 1'b0;
        dout_sop         = 1'b0;
        dout_eop         = 1'b0;
        dout_data        = '0;
        frame_done       = 1'b0;
        fifo_pop         = 1'b0;

        accept     = avm_read_q && !avm_waitrequest;
        remaining  = 32'(TOTAL) - 32'(req_cnt_q);
        burst_len  = (remaining < 32'(BURST)) ? remaining : 32'(BURST);
        // Space not yet claimed by buffered words or words still in flight
        free_words = 32'(FIFO_DEPTH) - 32'(fifo_count) - 32'(outstanding_q);

        outstanding_d = outstanding_q
                      + (accept ? CW'(avm_burstcount_q) : CW'(0))
                      - (avm_readdatavalid ? CW'(1) : CW'(0));

        // Burst accepted: advance the fetch pointer by the granted length
        if (accept) begin
            rd_addr_d  = rd_addr_q + 32'(avm_burstcount_q) * BYTES_PER_WORD;
            req_cnt_d  = req_cnt_q + CW'(avm_burstcount_q);
            avm_read_d = 1'b0;
        end

        // New burst only when none is pending, so the counters used for the
        // space check are always up to date
        if ((state_q == HDR || state_q == PIX) && !avm_read_q &&
            (32'(req_cnt_q) < 32'(TOTAL)) && (free_words >= burst_len)) begin
            avm_read_d       = 1'b1;
            avm_address_d    = rd_addr_q;
            avm_burstcount_d = 5'(burst_len);
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d    = HDR;
                    rd_addr_d  = base_addr;
                    req_cnt_d  = '0;
                    emit_cnt_d = '0;
                end
            end
            HDR: begin
                dout_valid = 1'b1;
                dout_sop   = 1'b1;
                dout_data  = {28'h0, VIP_PKT_VIDEO};
                if (dout_ready) begin
                    state_d = PIX;
                end
            end
            PIX: begin
                dout_valid = !fifo_empty;
                dout_data  = fifo_empty ? 32'h0 : fifo_head;
                dout_eop   = !fifo_empty && (emit_cnt_q == CW'(TOTAL-1));
                if (dout_ready && !fifo_empty) begin
                    fifo_pop   = 1'b1;
                    emit_cnt_d = emit_cnt_q + CW'(1);
                    if (emit_cnt_q == CW'(TOTAL-1)) begin
                        frame_done = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            rd_addr_q        <= '0;
            req_cnt_q        <= '0;
            emit_cnt_q       <= '0;
            outstanding_q    <= '0;
            avm_read_q       <= 1'b0;
            avm_address_q    <= '0;
            avm_burstcount_q <= '0;
        end else begin
            state_q          <= state_d;
            rd_addr_q        <= rd_addr_d;
            req_cnt_q        <= req_cnt_d;
            emit_cnt_q       <= emit_cnt_d;
            outstanding_q    <= outstanding_d;
            avm_read_q       <= avm_read_d;
            avm_address_q    <= avm_address_d;
            avm_burstcount_q <= avm_burstcount_d;
        end
    end

    assign avm_read       = avm_read_q;
    assign avm_address    = avm_address_q;
    assign avm_burstcount = avm_burstcount_q;
    assign busy           = (state_q != IDLE);

    // Burst admission reserves space, so a beat can never land on a full FIFO
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
                                    !(avm_readdatavalid && fifo_full));

endmodule

`default_nettype wire

// File: tb/tb_vip_frame_reader_ctrl.sv
// ============================================================================
// Module   : tb_vip_frame_reader_ctrl
// Purpose  : Randomized self-checking bench for vip_frame_reader_ctrl with a
//            behavioural SDRAM slave and a frame-level scoreboard.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vip_frame_reader_ctrl;

    localparam int H     = 10;
    localparam int V     = 3;
    localparam int B     = 4;
    localparam int FD    = 16;
    localparam int TOTAL = H * V;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] base_addr = 32'h0;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [4:0]  avm_burstcount;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'h0;
    logic        avm_readdatavalid = 1'b0;
    logic [31:0] dout_data;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        dout_sop;
    logic        dout_eop;
    logic        busy;
    logic        frame_done;

    always #5 clk = ~clk;

    vip_frame_reader_ctrl #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .BURST      (B),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .enable            (enable),
        .base_addr         (base_addr),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_burstcount    (avm_burstcount),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .dout_data         (dout_data),
        .dout_valid        (dout_valid),
        .dout_ready        (dout_ready),
        .dout_sop          (dout_sop),
        .dout_eop          (dout_eop),
        .busy              (busy),
        .frame_done        (frame_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // Stimulus knobs
    int ready_pct = 100;
    int wait_pct  = 0;
    int lat       = 1;
    int force_wait = 0;
    bit arm_wait  = 0;
    bit arm_drop  = 0;
    bit arm_base  = 0;
    logic [31:0] new_base = 32'h0;

    // Behavioural slave: beats queued with the cycle they are due
    logic [31:0] beat_addr[$];
    int          beat_due[$];

    // Frame-level reference state
    int cyc = 0;
    int req_words = 0;
    logic [31:0] req_base = 32'h0;
    int pix_idx = -1;
    logic [31:0] frm_base = 32'h0;
    int frames = 0;
    int accepted = 0;
    int popped = 0;
    int last_eop_cyc = -100;
    bit en_at_idle = 0;
    bit prev_wait = 0;
    logic [31:0] prev_addr = 32'h0;
    logic [4:0]  prev_bc = 5'h0;
    bit prev_stall = 0;
    logic [31:0] prev_data = 32'h0;

    task automatic clear_model();
        beat_addr.delete();
        beat_due.delete();
        req_words = 0;
        pix_idx = -1;
        accepted = 0;
        popped = 0;
        last_eop_cyc = -100;
        prev_wait = 0;
        prev_stall = 0;
        force_wait = 0;
    endtask

    task automatic monitor();
        int exp_len;
        check_eq("inflight_le_depth", 32'((accepted - popped) <= FD), 32'd1);

        if (prev_wait) begin
            check_eq("wait_hold_read", avm_read, 1);
            check_eq("wait_hold_addr", avm_address, prev_addr);
            check_eq("wait_hold_bc", avm_burstcount, prev_bc);
        end
        prev_wait = avm_read && avm_waitrequest;
        prev_addr = avm_address;
        prev_bc   = avm_burstcount;

        if (avm_read && !avm_waitrequest) begin
            if (req_words == 0) req_base = base_addr;
            exp_len = (TOTAL - req_words < B) ? TOTAL - req_words : B;
            check_eq("burst_len", avm_burstcount, exp_len);
            check_eq("burst_addr", avm_address, req_base + 32'(4 * req_words));
            for (int k = 0; k < int'(avm_burstcount); k++) begin
                beat_addr.push_back(avm_address + 32'(4 * k));
                beat_due.push_back(cyc + lat);
            end
            accepted += int'(avm_burstcount);
            req_words += exp_len;
            if (req_words >= TOTAL) req_words = 0;
        end

        if (prev_stall) begin
            check_eq("stall_hold_valid", dout_valid, 1);
            check_eq("stall_hold_data", dout_data, prev_data);
        end
        prev_stall = dout_valid && !dout_ready;
        prev_data  = dout_data;

        if (dout_valid && dout_ready) begin
            if (pix_idx < 0) begin
                check_eq("hdr_sop", dout_sop, 1);
                check_eq("hdr_data", dout_data, 32'h0);
                check_eq("hdr_eop", dout_eop, 0);
                frm_base = base_addr;
                pix_idx = 0;
            end else begin
                check_eq("pix_sop", dout_sop, 0);
                check_eq("pix_data", dout_data, (frm_base >> 2) + 32'(pix_idx));
                check_eq("pix_eop", dout_eop, 32'(pix_idx == TOTAL - 1));
                check_eq("frame_done", frame_done, 32'(pix_idx == TOTAL - 1));
                if (pix_idx == 10 && arm_drop) begin enable = 1'b0; arm_drop = 0; end
                if (pix_idx == 10 && arm_base) begin base_addr = new_base; arm_base = 0; end
                popped++;
                pix_idx++;
                if (pix_idx == TOTAL) begin
                    pix_idx = -1;
                    frames++;
                    last_eop_cyc = cyc;
                end
            end
        end else begin
            check_eq("frame_done_quiet", frame_done, 0);
        end

        // Two-cycle gap (DONE, IDLE) and enable sampling in IDLE
        if (cyc == last_eop_cyc + 1) check_eq("busy_done", busy, 1);
        if (cyc == last_eop_cyc + 2) begin
            check_eq("busy_idle", busy, 0);
            en_at_idle = enable;
        end
        if (cyc == last_eop_cyc + 3) check_eq("busy_restart", busy, 32'(en_at_idle));
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        dout_ready = ($urandom_range(99) < ready_pct);
        if (arm_wait && avm_read) begin force_wait = 5; arm_wait = 0; end
        if (force_wait > 0) begin
            avm_waitrequest = 1'b1;
            force_wait--;
        end else begin
            avm_waitrequest = ($urandom_range(99) < wait_pct);
        end
        if (beat_due.size() > 0 && beat_due[0] <= cyc) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = beat_addr[0] >> 2;
            void'(beat_addr.pop_front());
            void'(beat_due.pop_front());
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata = $urandom;
        end
        #1;
        monitor();
    endtask

    task automatic run_frames(input int n);
        int target = frames + n;
        for (int i = 0; i < 4000 && frames < target; i++) step();
        if (frames < target) check_eq("frame_timeout", frames, target);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_avm_read", avm_read, 0);
        check_eq("rst_avm_addr", avm_address, 0);
        check_eq("rst_avm_bc", avm_burstcount, 0);
        check_eq("rst_valid", dout_valid, 0);
        check_eq("rst_sop", dout_sop, 0);
        check_eq("rst_eop", dout_eop, 0);
        check_eq("rst_data", dout_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_frame_done", frame_done, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        // Basic frames: zero-wait slave, always ready, back-to-back
        base_addr = 32'h0;
        enable = 1'b1;
        run_frames(2);

        // Backpressure, read latency, waitrequest stretch, base change
        ready_pct = 30; wait_pct = 20; lat = 4;
        arm_wait = 1;
        arm_base = 1; new_base = 32'h2000;
        run_frames(2);
        check_eq("wait_stretch_seen", 32'(arm_wait), 0);

        // Enable dropped mid-frame: frame completes, nothing restarts
        ready_pct = 60;
        arm_drop = 1;
        run_frames(1);
        repeat (8) step();
        check_eq("drop_busy", busy, 0);
        check_eq("drop_avm_read", avm_read, 0);

        // Re-enable from idle with a new base
        base_addr = 32'h1000;
        enable = 1'b1;
        run_frames(1);

        // Reset mid-frame, then clean restart at base_addr
        for (int i = 0; i < 2000 && pix_idx < 12; i++) step();
        check_eq("reached_mid_frame", 32'(pix_idx >= 12), 1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        avm_readdatavalid = 1'b0;
        #1;
        check_reset_outputs();
        clear_model();
        base_addr = 32'h3000;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_frames(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
